mig_ui_responder: RTL and testbench

Synthesizable responder for the MIG 7-series user (app_*) interface: accepts commands and write data from `ddr_ctrl` or any app-interface initiator, stores data in an internal 128-bit-wide memory, and returns read data in order after a fixed latency. It stands in for MIG plus DDR in the DNN simulation benches and in FPGA loopback builds without external DRAM.

---
 rtl/mig_ui_pkg.sv | 35 +++
 rtl/mig_ui_fifo.sv | 71 +++++++
 rtl/mig_ui_responder.sv | 187 ++++++++++++++++++
 tb/tb_mig_ui_responder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_ui_pkg.sv
// Shared definitions for the MIG 7-series app-interface responder:
// command encodings, UI field widths, stall LFSR seed and small helpers.
package mig_ui_pkg;

    localparam int UI_ADDR_W = 27;
    localparam int UI_DATA_W = 128;
    localparam int UI_MASK_W = 16;

    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Replace every byte whose mask bit is 0; a set mask bit keeps the old byte.
    function automatic logic [UI_DATA_W-1:0] merge_bytes(
        input logic [UI_DATA_W-1:0] old_word,
        input logic [UI_DATA_W-1:0] new_word,
        input logic [UI_MASK_W-1:0] mask
    );
        logic [UI_DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < UI_MASK_W; b++) begin
            if (!mask[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mig_ui_fifo.sv
// Synchronous show-ahead FIFO (DEPTH a power of two, at least 2).
// full_o/empty_o come straight from registers so ready signals built on
// them have no combinational path from the push/pop requests.
module mig_ui_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Next occupancy from this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mig_ui_responder.sv
// MIG 7-series app-interface responder: command FIFO + write-data FIFO,
// in-order executor over a 128-bit internal memory, fixed-latency read return.
// Optional MIG_RESP_STALL_EN adds LFSR-driven backpressure on both ready outputs.
module mig_ui_responder
    import mig_ui_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int RD_LAT       = 4,
    parameter int CMD_DEPTH    = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                 ui_clk_i,
    input  logic                 ui_rst_n_i,
    input  logic [UI_ADDR_W-1:0] app_addr_i,
    input  logic [2:0]           app_cmd_i,
    input  logic                 app_en_i,
    output logic                 app_rdy_o,
    input  logic [UI_DATA_W-1:0] app_wdf_data_i,
    input  logic [UI_MASK_W-1:0] app_wdf_mask_i,
    input  logic                 app_wdf_wren_i,
    input  logic                 app_wdf_end_i,
    output logic                 app_wdf_rdy_o,
    output logic [UI_DATA_W-1:0] app_rd_data_o,
    output logic                 app_rd_data_valid_o,
    output logic                 app_rd_data_end_o,
    output logic                 init_calib_complete_o,
    output logic                 cmd_err_o
);

    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int CMD_W     = 3 + ADDR_W;
    localparam int WDF_W     = UI_DATA_W + UI_MASK_W;
    localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
    localparam logic [CAL_W-1:0] CAL_ONE  = {{(CAL_W-1){1'b0}}, 1'b1};
    localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CALIB_CYCLES - 1);

    logic [CAL_W-1:0]     cal_cnt_q;
    logic                 calib_q;
    logic                 cmd_gate;
    logic                 wdf_gate;

    logic                 cmd_push;
    logic                 cmd_pop;
    logic [CMD_W-1:0]     cmd_dout;
    logic                 cmd_full;
    logic                 cmd_empty;
    logic                 wdf_push;
    logic                 wdf_pop;
    logic [WDF_W-1:0]     wdf_dout;
    logic                 wdf_full;
    logic                 wdf_empty;

    logic [2:0]           head_cmd;
    logic [ADDR_W-1:0]    head_idx;
    logic [UI_DATA_W-1:0] wdf_data;
    logic [UI_MASK_W-1:0] wdf_mask;
    logic                 exec_rd;
    logic                 exec_wr;
    logic                 exec_ill;
    logic                 err_q;

    logic [UI_DATA_W-1:0] mem_q [MEM_DEPTH] = '{default: '0};
    logic                 pipe_vld_q  [RD_LAT+1];
    logic [UI_DATA_W-1:0] pipe_data_q [RD_LAT+1];

    // Byte offset and address bits above the memory depth are ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{app_addr_i[2:0], app_addr_i[UI_ADDR_W-1:ADDR_W+3]};

    // Calibration counter: runs once from reset release, then parks.
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
        end else if (!calib_q) begin
            cal_cnt_q <= cal_cnt_q + CAL_ONE;
            if (cal_cnt_q == CAL_LAST) calib_q <= 1'b1;
        end
    end

`ifdef MIG_RESP_STALL_EN
    logic [15:0] lfsr_q;

    // Backpressure pattern generator, free-running once calibrated.
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (calib_q) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign cmd_gate = (lfsr_q[1:0] != 2'b00);
    assign wdf_gate = (lfsr_q[3:2] != 2'b00);
`else
    assign cmd_gate = 1'b1;
    assign wdf_gate = 1'b1;
`endif

    assign app_rdy_o     = calib_q && !cmd_full && cmd_gate;
    assign app_wdf_rdy_o = calib_q && !wdf_full && wdf_gate;
    assign cmd_push      = app_en_i && app_rdy_o;
    assign wdf_push      = app_wdf_wren_i && app_wdf_rdy_o;

    mig_ui_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (ui_clk_i),
        .rst_n_i (ui_rst_n_i),
        .push_i  (cmd_push),
        .din_i   ({app_cmd_i, app_addr_i[ADDR_W+2:3]}),
        .pop_i   (cmd_pop),
        .dout_o  (cmd_dout),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    mig_ui_fifo #(.WIDTH(WDF_W), .DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk_i   (ui_clk_i),
        .rst_n_i (ui_rst_n_i),
        .push_i  (wdf_push),
        .din_i   ({app_wdf_data_i, app_wdf_mask_i}),
        .pop_i   (wdf_pop),
        .dout_o  (wdf_dout),
        .full_o  (wdf_full),
        .empty_o (wdf_empty)
    );

    assign head_cmd = cmd_dout[CMD_W-1:ADDR_W];
    assign head_idx = cmd_dout[ADDR_W-1:0];
    assign wdf_data = wdf_dout[WDF_W-1:UI_MASK_W];
    assign wdf_mask = wdf_dout[UI_MASK_W-1:0];

    // Executor decode: one head command per cycle; a write waits for its data.
    always_comb begin
        exec_rd  = 1'b0;
        exec_wr  = 1'b0;
        exec_ill = 1'b0;
        if (!cmd_empty) begin
            case (head_cmd)
                CMD_READ:  exec_rd  = 1'b1;
                CMD_WRITE: exec_wr  = !wdf_empty;
                default:   exec_ill = 1'b1;
            endcase
        end
    end

    assign cmd_pop = exec_rd || exec_wr || exec_ill;
    assign wdf_pop = exec_wr;

    // Masked write into the word array; contents survive reset.
    always_ff @(posedge ui_clk_i) begin
        if (exec_wr) mem_q[head_idx] <= merge_bytes(mem_q[head_idx], wdf_data, wdf_mask);
    end

    // Synchronous read (stage 0) followed by RD_LAT delay stages.
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= exec_rd;
            if (exec_rd) pipe_data_q[0] <= mem_q[head_idx];
            for (int i = 1; i <= RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    // Sticky error: illegal opcode executed, or a data beat accepted without end.
    always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            err_q <= 1'b0;
        end else if (exec_ill || (wdf_push && !app_wdf_end_i)) begin
            err_q <= 1'b1;
        end
    end

    assign app_rd_data_o         = pipe_data_q[RD_LAT];
    assign app_rd_data_valid_o   = pipe_vld_q[RD_LAT];
    assign app_rd_data_end_o     = pipe_vld_q[RD_LAT];
    assign init_calib_complete_o = calib_q;
    assign cmd_err_o             = err_q;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Bench for mig_ui_responder: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized traffic phase.
module tb_mig_ui_responder;

    localparam int ADDR_W       = 10;
    localparam int RD_LAT       = 4;
    localparam int CMD_DEPTH    = 4;
    localparam int WDF_DEPTH    = 4;
    localparam int CALIB_CYCLES = 16;

    logic         ui_clk_i = 1'b0;
    logic         ui_rst_n_i = 1'b0;
    logic [26:0]  app_addr_i = '0;
    logic [2:0]   app_cmd_i = '0;
    logic         app_en_i = 1'b0;
    logic         app_rdy_o;
    logic [127:0] app_wdf_data_i = '0;
    logic [15:0]  app_wdf_mask_i = '0;
    logic         app_wdf_wren_i = 1'b0;
    logic         app_wdf_end_i = 1'b1;
    logic         app_wdf_rdy_o;
    logic [127:0] app_rd_data_o;
    logic         app_rd_data_valid_o;
    logic         app_rd_data_end_o;
    logic         init_calib_complete_o;
    logic         cmd_err_o;

    int total = 0;
    int bad = 0;

    mig_ui_responder #(
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CMD_DEPTH(CMD_DEPTH),
        .WDF_DEPTH(WDF_DEPTH), .CALIB_CYCLES(CALIB_CYCLES)
    ) dut (
        .ui_clk_i              (ui_clk_i),
        .ui_rst_n_i            (ui_rst_n_i),
        .app_addr_i            (app_addr_i),
        .app_cmd_i             (app_cmd_i),
        .app_en_i              (app_en_i),
        .app_rdy_o             (app_rdy_o),
        .app_wdf_data_i        (app_wdf_data_i),
        .app_wdf_mask_i        (app_wdf_mask_i),
        .app_wdf_wren_i        (app_wdf_wren_i),
        .app_wdf_end_i         (app_wdf_end_i),
        .app_wdf_rdy_o         (app_wdf_rdy_o),
        .app_rd_data_o         (app_rd_data_o),
        .app_rd_data_valid_o   (app_rd_data_valid_o),
        .app_rd_data_end_o     (app_rd_data_end_o),
        .init_calib_complete_o (init_calib_complete_o),
        .cmd_err_o             (cmd_err_o)
    );

    always #5 ui_clk_i = ~ui_clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    function automatic logic [127:0] pat(input int k);
        return {4{32'hC0DE0000 | 32'(k)}};
    endfunction

    // Reference model: memory image, pending command / data queues, return schedule.
    logic [127:0] mm [1 << ADDR_W];
    logic [12:0]  cq [$];
    logic [143:0] wq [$];
    logic         sh_v [RD_LAT+1];
    logic [127:0] sh_d [RD_LAT+1];
    int           m_cnt = 0;
    logic         m_err = 1'b0;
    logic         m_cal;
    logic         m_nv;
    logic [127:0] m_nd;
    logic [12:0]  m_h;
    logic [143:0] m_w;
    logic         m_crdy;
    logic         m_wrdy;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mm[i] = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            sh_v[i] = 1'b0;
            sh_d[i] = '0;
        end
    end

    always @(posedge ui_clk_i or negedge ui_rst_n_i) begin
        if (!ui_rst_n_i) begin
            cq.delete();
            wq.delete();
            for (int i = 0; i <= RD_LAT; i++) begin
                sh_v[i] = 1'b0;
                sh_d[i] = '0;
            end
            m_cnt = 0;
            m_err = 1'b0;
        end else begin
            m_cal  = (m_cnt >= CALIB_CYCLES);
            m_crdy = m_cal && (cq.size() < CMD_DEPTH);
            m_wrdy = m_cal && (wq.size() < WDF_DEPTH);
            m_nv = 1'b0;
            m_nd = '0;
            if (cq.size() > 0) begin
                m_h = cq[0];
                if (m_h[12:10] == 3'd1) begin
                    m_nv = 1'b1;
                    m_nd = mm[m_h[9:0]];
                    void'(cq.pop_front());
                end else if (m_h[12:10] == 3'd0) begin
                    if (wq.size() > 0) begin
                        m_w = wq.pop_front();
                        void'(cq.pop_front());
                        for (int b = 0; b < 16; b++)
                            if (!m_w[b]) mm[m_h[9:0]][b*8 +: 8] = m_w[16 + b*8 +: 8];
                    end
                end else begin
                    void'(cq.pop_front());
                    m_err = 1'b1;
                end
            end
            if (app_en_i && m_crdy) cq.push_back({app_cmd_i, app_addr_i[12:3]});
            if (app_wdf_wren_i && m_wrdy) begin
                wq.push_back({app_wdf_data_i, app_wdf_mask_i});
                if (!app_wdf_end_i) m_err = 1'b1;
            end
            for (int i = RD_LAT; i >= 1; i--) begin
                sh_v[i] = sh_v[i-1];
                sh_d[i] = sh_d[i-1];
            end
            sh_v[0] = m_nv;
            sh_d[0] = m_nd;
            if (m_cnt < CALIB_CYCLES) m_cnt++;
        end
    end

    // Per-cycle compare against the model, plus a log of returned read data.
    logic [127:0] rd_log [$];
    int           vrun = 0;
    int           vmax = 0;

    always @(negedge ui_clk_i) begin
        if (!ui_rst_n_i) begin
            chk("rst_rd_valid", app_rd_data_valid_o, 0);
            chk("rst_rd_data", app_rd_data_o, 0);
            chk("rst_app_rdy", app_rdy_o, 0);
            chk("rst_wdf_rdy", app_wdf_rdy_o, 0);
            chk("rst_calib", init_calib_complete_o, 0);
            chk("rst_cmd_err", cmd_err_o, 0);
        end else begin
            chk("rd_valid", app_rd_data_valid_o, sh_v[RD_LAT]);
            chk("rd_end", app_rd_data_end_o, sh_v[RD_LAT]);
            if (sh_v[RD_LAT]) chk("rd_data", app_rd_data_o, sh_d[RD_LAT]);
            chk("app_rdy", app_rdy_o, (m_cnt >= CALIB_CYCLES) && (cq.size() < CMD_DEPTH));
            chk("wdf_rdy", app_wdf_rdy_o, (m_cnt >= CALIB_CYCLES) && (wq.size() < WDF_DEPTH));
            chk("calib", init_calib_complete_o, m_cnt >= CALIB_CYCLES);
            chk("cmd_err", cmd_err_o, m_err);
        end
        if (app_rd_data_valid_o) begin
            rd_log.push_back(app_rd_data_o);
            vrun++;
            if (vrun > vmax) vmax = vrun;
        end else begin
            vrun = 0;
        end
    end

    // Directed drivers; called and returning on a falling edge.
    task automatic do_cmd(input logic [2:0] c, input logic [26:0] a);
        int n = 0;
        app_cmd_i  = c;
        app_addr_i = a;
        app_en_i   = 1'b1;
        while (!app_rdy_o && n < 200) begin
            @(negedge ui_clk_i);
            n++;
        end
        if (n >= 200) timeout("cmd_accept");
        @(negedge ui_clk_i);
        app_en_i = 1'b0;
    endtask

    task automatic do_wdf(input logic [127:0] d, input logic [15:0] m);
        int n = 0;
        app_wdf_data_i = d;
        app_wdf_mask_i = m;
        app_wdf_end_i  = 1'b1;
        app_wdf_wren_i = 1'b1;
        while (!app_wdf_rdy_o && n < 200) begin
            @(negedge ui_clk_i);
            n++;
        end
        if (n >= 200) timeout("wdf_accept");
        @(negedge ui_clk_i);
        app_wdf_wren_i = 1'b0;
    endtask

    task automatic wait_valid(output int k, output logic [127:0] d);
        k = 0;
        d = '0;
        while (k < 40) begin
            @(negedge ui_clk_i);
            k++;
            if (app_rd_data_valid_o) begin
                d = app_rd_data_o;
                break;
            end
        end
        if (!app_rd_data_valid_o) timeout("read_return");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [127:0] rd;

        repeat (2) @(negedge ui_clk_i);
        chk("reset_rdy", app_rdy_o, 0);
        chk("reset_calib", init_calib_complete_o, 0);
        chk("reset_valid", app_rd_data_valid_o, 0);
        #2 ui_rst_n_i = 1'b1;

        // Calibration completes on the 16th rising edge after release.
        for (int i = 1; i <= 20; i++) begin
            @(posedge ui_clk_i);
            #1;
            chk($sformatf("calib_edge%0d", i), init_calib_complete_o, (i >= 16));
            chk($sformatf("rdy_edge%0d", i), app_rdy_o, (i >= 16));
        end
        @(negedge ui_clk_i);

        // Word 0 cleared, then data-before-command write and read-back at 0x40.
        do_wdf('0, 16'h0000);
        do_cmd(3'd0, 27'h0);
        do_wdf({16{8'h11}}, 16'h0000);
        do_cmd(3'd0, 27'h40);
        do_cmd(3'd1, 27'h40);
        wait_valid(lat, rd);
        chk("read_latency", 128'(lat), 128'(RD_LAT + 1));
        chk("read_0x40", rd, {16{8'h11}});

        // Masked write: only bytes 0..3 land.
        do_wdf({128{1'b1}}, 16'hFFF0);
        do_cmd(3'd0, 27'h0);
        do_cmd(3'd1, 27'h0);
        wait_valid(lat, rd);
        chk("masked_write", rd, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);

        // Writes without data fill the command FIFO after 4 entries.
        repeat (10) @(negedge ui_clk_i);
        for (int k = 1; k <= 4; k++) do_cmd(3'd0, 27'(k << 3));
        chk("cmd_fifo_full", app_rdy_o, 0);
        app_cmd_i  = 3'd0;
        app_addr_i = 27'(5 << 3);
        app_en_i   = 1'b1;
        repeat (3) @(negedge ui_clk_i);
        chk("cmd_fifo_full_held", app_rdy_o, 0);
        app_en_i = 1'b0;
        for (int k = 1; k <= 4; k++) do_wdf(pat(k), 16'h0000);
        repeat (3) @(negedge ui_clk_i);
        chk("cmd_rdy_back", app_rdy_o, 1);
        for (int k = 5; k <= 7; k++) begin
            do_wdf(pat(k), 16'h0000);
            do_cmd(3'd0, 27'(k << 3));
        end

        // Back-to-back reads of words 0..7 (upper address bits set: must wrap).
        repeat (10) @(negedge ui_clk_i);
        rd_log.delete();
        vmax = 0;
        for (int k = 0; k < 8; k++) do_cmd(3'd1, 27'h4000000 | 27'(k << 3) | 27'(k & 7));
        repeat (15) @(negedge ui_clk_i);
        chk("burst_run", 128'(vmax), 128'd8);
        chk("burst_count", 128'(rd_log.size()), 128'd8);
        if (rd_log.size() >= 2) begin
            chk("burst_word0", rd_log[0], 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF);
            chk("burst_word1", rd_log[1], pat(1));
        end

        // Illegal command: sticky error.
        chk("err_before", cmd_err_o, 0);
        do_cmd(3'd2, 27'h0);
        repeat (2) @(negedge ui_clk_i);
        chk("err_set", cmd_err_o, 1);
        repeat (10) @(negedge ui_clk_i);
        chk("err_sticky", cmd_err_o, 1);

        // Async reset in the middle of a read burst.
        for (int k = 0; k < 8; k++) do_cmd(3'd1, 27'(k << 3));
        chk("burst_live", app_rd_data_valid_o, 1);
        #2 ui_rst_n_i = 1'b0;
        #1;
        chk("async_valid_drop", app_rd_data_valid_o, 0);
        chk("async_data_zero", app_rd_data_o, 0);
        chk("async_rdy_drop", app_rdy_o, 0);
        repeat (3) @(negedge ui_clk_i);
        #2 ui_rst_n_i = 1'b1;
        rd_log.delete();
        repeat (25) @(negedge ui_clk_i);
        chk("no_stale_reads", 128'(rd_log.size()), 0);
        chk("err_cleared", cmd_err_o, 0);
        chk("recalibrated", init_calib_complete_o, 1);

        // Randomized traffic; words 0..15 with random ignored address bits.
        for (int n = 0; n < 2000; n++) begin
            app_en_i       = 1'($urandom_range(0, 1));
            app_cmd_i      = 3'($urandom_range(0, 1));
            app_addr_i     = 27'(($urandom & 32'h3FFF) << 13) | 27'($urandom_range(0, 15) << 3)
                             | 27'($urandom_range(0, 7));
            app_wdf_wren_i = 1'($urandom_range(0, 1));
            app_wdf_data_i = {$urandom, $urandom, $urandom, $urandom};
            app_wdf_mask_i = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            app_wdf_end_i  = 1'b1;
            @(negedge ui_clk_i);
        end
        app_en_i       = 1'b0;
        app_wdf_wren_i = 1'b0;
        repeat (30) @(negedge ui_clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
